// File: rtl/chan_blk_sched_pkg.sv
// rtl/chan_blk_sched_pkg.sv - shared constants and state encoding for the block scheduler
// Contents:
//   DEF_IDLE_WORD  default K28.5 idle/comma word sent with kchar=1
//   HDR_*          header word field positions (flag, channel id, length)
//   CH_W           width of a channel index (up to 32 channels)
//   state_t        scheduler FSM states
package chan_blk_sched_pkg;

   localparam logic [15:0] DEF_IDLE_WORD = 16'h50BC;

   localparam int HDR_FLAG   = 15;
   localparam int HDR_CH_HI  = 14;
   localparam int HDR_CH_LO  = 9;
   localparam int HDR_LEN_HI = 8;
   localparam int HDR_LEN_LO = 0;

   localparam int CH_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DATA = 2'd2
   } state_t;

endpackage

// File: rtl/chan_blk_sched_if.sv
// rtl/chan_blk_sched_if.sv - FIFO-side and link-side signal bundle of the block scheduler
// Signals:
//   req      per-channel FIFO not-empty (head word valid)
//   din      per-channel FWFT head words, channel i at din[16*i +: 16]
//   rd       per-channel read strobe, head word consumed while high
//   dataout  registered link word
//   kchar    dataout is an idle K-char word
// Modports: master drives the FIFO side and watches the link, slave is the scheduler.
interface chan_blk_sched_if #(
   parameter int NCH = 17
);
   logic [NCH-1:0]    req;
   logic [16*NCH-1:0] din;
   logic [NCH-1:0]    rd;
   logic [15:0]       dataout;
   logic              kchar;

   modport master (output req, output din, input rd, input dataout, input kchar);
   modport slave  (input req, input din, output rd, output dataout, output kchar);
endinterface

// File: rtl/chan_blk_sched_rr_pick.sv
// rtl/chan_blk_sched_rr_pick.sv - combinational rotating-priority encoder
// Ports:
//   req  in   NCH   request vector
//   ptr  in   CH_W  highest-priority index (must be < NCH)
//   win  out  CH_W  first requesting index at or above ptr, modulo NCH
//   vld  out  1     any request present; win is meaningless when low
module chan_blk_sched_rr_pick
   import chan_blk_sched_pkg::*;
#(
   parameter int NCH = 17
) (
   input  logic [NCH-1:0]  req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] win,
   output logic            vld
);

   localparam int SUM_W = CH_W + 1;

   logic [NCH-1:0]   rot;
   logic [CH_W-1:0]  off;
   logic [SUM_W-1:0] sum;

   always_comb begin
      // Rotate so that bit 0 of rot is channel ptr, then take the lowest set bit.
      rot = NCH'({req, req} >> ptr);
      off = '0;
      for (int j = NCH - 1; j >= 0; j--) begin
         if (rot[j]) off = CH_W'(j);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      win = (sum >= SUM_W'(NCH)) ? CH_W'(sum - SUM_W'(NCH)) : sum[CH_W-1:0];
      vld = |req;
   end

endmodule

// File: rtl/chan_blk_sched.sv
// rtl/chan_blk_sched.sv - round-robin block scheduler onto one 16-bit link word stream
// Ports:
//   clk      in   1     rising-edge clock
//   reset    in   1     synchronous active-high reset
//   en       in   1     allow new grants; a running block always finishes
//   bus      slave      req/din/rd FIFO side, dataout/kchar link side
//   busy     out  1     a block is granted (HDR or DATA)
//   cur_ch   out  5     granted channel, valid while busy
//   err_fmt  out  1     pulse: granted head word lacked the header flag
//   err_tmo  out  1     pulse: block abandoned after TMO consecutive stalls
//   blk_cnt  out  16    completed blocks, wrapping
module chan_blk_sched
   import chan_blk_sched_pkg::*;
#(
   parameter int          NCH       = 17,
   parameter int          LENW      = 9,
   parameter logic [15:0] IDLE_WORD = DEF_IDLE_WORD,
   parameter int          TMO       = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   chan_blk_sched_if.slave   bus,
   output logic              busy,
   output logic [CH_W-1:0]   cur_ch,
   output logic              err_fmt,
   output logic              err_tmo,
   output logic [15:0]       blk_cnt
);

   localparam int SW = $clog2(TMO + 1);

   state_t            state, state_n;
   logic [CH_W-1:0]   ptr, ptr_n;
   logic [CH_W-1:0]   gnt, gnt_n;
   logic [LENW-1:0]   wcnt, wcnt_n;
   logic [SW-1:0]     stall, stall_n;
   logic [15:0]       dout_q, dout_n;
   logic              kchar_q, kchar_n;
   logic              efmt_n, etmo_n;
   logic [15:0]       cnt_n;
   logic              done;

   logic [CH_W-1:0]   pick;
   logic              pick_vld;
   logic              req_g;
   logic [15:0]       head;
   logic              fire;

   chan_blk_sched_rr_pick #(.NCH(NCH)) u_pick (
      .req (bus.req),
      .ptr (ptr),
      .win (pick),
      .vld (pick_vld)
   );

   // Select the granted channel's request and head word.
   always_comb begin
      req_g = 1'b0;
      head  = '0;
      for (int i = 0; i < NCH; i++) begin
         if (gnt == CH_W'(i)) begin
            req_g = bus.req[i];
            head  = bus.din[16*i +: 16];
         end
      end
   end

   // A word is consumed whenever the granted FIFO has one during HDR or DATA.
   assign fire = ((state == HDR) || (state == DATA)) && req_g;

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         bus.rd[i] = fire && (gnt == CH_W'(i));
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      gnt_n   = gnt;
      wcnt_n  = wcnt;
      stall_n = stall;
      dout_n  = IDLE_WORD;
      kchar_n = 1'b1;
      efmt_n  = 1'b0;
      etmo_n  = 1'b0;
      cnt_n   = blk_cnt;
      done    = 1'b0;

      case (state)
         IDLE: begin
            if (en && pick_vld) begin
               gnt_n   = pick;
               stall_n = '0;
               state_n = HDR;
            end
         end
         HDR, DATA: begin
            if (req_g) begin
               stall_n = '0;
               if (state == HDR) begin
                  if (head[HDR_FLAG]) begin
                     dout_n  = head;
                     kchar_n = 1'b0;
                     wcnt_n  = head[LENW-1:0];
                     if (head[LENW-1:0] == '0) begin
                        done  = 1'b1;
                        cnt_n = blk_cnt + 16'd1;
                     end else begin
                        state_n = DATA;
                     end
                  end else begin
                     // Malformed head word is consumed and dropped.
                     efmt_n = 1'b1;
                     done   = 1'b1;
                  end
               end else begin
                  dout_n  = head;
                  kchar_n = 1'b0;
                  wcnt_n  = wcnt - 1'b1;
                  if (wcnt == LENW'(1)) begin
                     done  = 1'b1;
                     cnt_n = blk_cnt + 16'd1;
                  end
               end
            end else if (stall == SW'(TMO - 1)) begin
               // This is the TMO-th consecutive empty cycle.
               etmo_n = 1'b1;
               done   = 1'b1;
            end else begin
               stall_n = stall + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase

      if (done) begin
         state_n = IDLE;
         stall_n = '0;
         ptr_n   = (gnt == CH_W'(NCH - 1)) ? '0 : gnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         wcnt    <= '0;
         stall   <= '0;
         dout_q  <= IDLE_WORD;
         kchar_q <= 1'b1;
         err_fmt <= 1'b0;
         err_tmo <= 1'b0;
         blk_cnt <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         gnt     <= gnt_n;
         wcnt    <= wcnt_n;
         stall   <= stall_n;
         dout_q  <= dout_n;
         kchar_q <= kchar_n;
         err_fmt <= efmt_n;
         err_tmo <= etmo_n;
         blk_cnt <= cnt_n;
      end
   end

   assign bus.dataout = dout_q;
   assign bus.kchar   = kchar_q;
   assign busy        = (state != IDLE);
   assign cur_ch      = gnt;

endmodule

// File: tb/tb_chan_blk_sched.sv
// tb/tb_chan_blk_sched.sv - self-checking bench for chan_blk_sched
module tb_chan_blk_sched;
   import chan_blk_sched_pkg::*;

   localparam int          NCH = 17;
   localparam int          TMO = 1023;
   localparam logic [15:0] IW  = 16'h50BC;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        busy, err_fmt, err_tmo;
   logic [4:0]  cur_ch;
   logic [15:0] blk_cnt;

   chan_blk_sched_if #(.NCH(NCH)) bus ();

   chan_blk_sched #(.NCH(NCH), .LENW(9), .IDLE_WORD(16'h50BC), .TMO(TMO)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .bus     (bus),
      .busy    (busy),
      .cur_ch  (cur_ch),
      .err_fmt (err_fmt),
      .err_tmo (err_tmo),
      .blk_cnt (blk_cnt)
   );

   always #5 clk = ~clk;

   // Upstream FIFOs and stimulus controls (applied at the next negedge)
   logic [15:0]    fifo [NCH][$];
   logic [NCH-1:0] hold = '0;
   logic           rst_s = 1'b1;
   logic           en_s = 1'b0;

   int errors = 0;
   int checks = 0;

   // Model: block-level view of the link
   int          m_g, m_left, m_stall, m_p;
   bit          m_hdr;
   logic [15:0] m_cnt, m_dout;
   logic        m_k, m_ef, m_et;

   // Observations
   int          rd_cnt [NCH];
   int          ef_cnt, et_cnt;
   int          grants [$];
   logic        prev_busy = 1'b0;
   logic [16:0] stream [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] hdr(input int c, input int l);
      return 16'h8000 | 16'(c << 9) | 16'(l);
   endfunction

   task automatic model_reset();
      m_g = -1; m_left = 0; m_stall = 0; m_p = 0; m_hdr = 0;
      m_cnt = 16'h0; m_dout = IW; m_k = 1'b1; m_ef = 1'b0; m_et = 1'b0;
   endtask

   task automatic model_end(input bit ok);
      m_p = (m_g + 1) % NCH;
      if (ok) m_cnt = m_cnt + 16'd1;
      m_g = -1;
      m_stall = 0;
   endtask

   // Advance the model by one clock given the inputs currently driven.
   task automatic model_step();
      logic [15:0]    w;
      logic [NCH-1:0] rq;
      rq = bus.req;
      if (reset) begin
         model_reset();
         return;
      end
      m_dout = IW; m_k = 1'b1; m_ef = 1'b0; m_et = 1'b0;
      if (m_g < 0) begin
         if (en && rq != '0) begin
            for (int k = 0; k < NCH; k++) begin
               if (rq[(m_p + k) % NCH]) begin
                  m_g = (m_p + k) % NCH; m_hdr = 1; m_stall = 0;
                  break;
               end
            end
         end
      end else if (rq[m_g]) begin
         w = bus.din[16*m_g +: 16];
         m_stall = 0;
         if (m_hdr && !w[15]) begin
            m_ef = 1'b1;
            model_end(0);
         end else begin
            m_dout = w; m_k = 1'b0;
            if (m_hdr) begin m_hdr = 0; m_left = int'(w[8:0]); end
            else m_left--;
            if (m_left == 0) model_end(1);
         end
      end else begin
         m_stall++;
         if (m_stall == TMO) begin
            m_et = 1'b1;
            model_end(0);
         end
      end
   endtask

   task automatic drive();
      reset = rst_s;
      en    = en_s;
      for (int i = 0; i < NCH; i++) begin
         bus.req[i]         = (fifo[i].size() > 0) && !hold[i];
         bus.din[16*i +: 16] = (fifo[i].size() > 0) ? fifo[i][0] : 16'h0;
      end
   endtask

   // One clock: drive, compare against the model, pop consumed words, step the model.
   task automatic cycle();
      logic [NCH-1:0] exp_rd;
      @(negedge clk);
      drive();
      #1;
      exp_rd = '0;
      if (m_g >= 0 && bus.req[m_g]) exp_rd[m_g] = 1'b1;
      chk("rd", 32'(bus.rd), 32'(exp_rd));
      chk("dataout", 32'(bus.dataout), 32'(m_dout));
      chk("kchar", 32'(bus.kchar), 32'(m_k));
      chk("busy", 32'(busy), 32'(m_g >= 0));
      if (m_g >= 0) chk("cur_ch", 32'(cur_ch), 32'(m_g));
      chk("err_fmt", 32'(err_fmt), 32'(m_ef));
      chk("err_tmo", 32'(err_tmo), 32'(m_et));
      chk("blk_cnt", 32'(blk_cnt), 32'(m_cnt));
      if (busy && !prev_busy) grants.push_back(int'(cur_ch));
      prev_busy = busy;
      if (err_fmt) ef_cnt++;
      if (err_tmo) et_cnt++;
      stream.push_back({bus.kchar, bus.dataout});
      for (int i = 0; i < NCH; i++) begin
         if (bus.rd[i]) begin
            rd_cnt[i]++;
            if (fifo[i].size() > 0) void'(fifo[i].pop_front());
         end
      end
      model_step();
   endtask

   task automatic do_reset();
      rst_s = 1'b1;
      hold = '0;
      for (int i = 0; i < NCH; i++) fifo[i].delete();
      repeat (3) cycle();
      rst_s = 1'b0;
   endtask

   function automatic int find_word(input logic [15:0] w);
      for (int i = 0; i < stream.size(); i++)
         if (stream[i] == {1'b0, w}) return i;
      return -1000;
   endfunction

   function automatic int data_words();
      int n = 0;
      for (int i = 0; i < stream.size(); i++)
         if (!stream[i][16]) n++;
      return n;
   endfunction

   initial begin
      int n, pre, i2, i3;
      model_reset();
      for (int i = 0; i < NCH; i++) rd_cnt[i] = 0;
      ef_cnt = 0; et_cnt = 0;
      drive();
      repeat (2) cycle();

      // Idle link after reset
      rst_s = 1'b0; en_s = 1'b1;
      repeat (20) cycle();
      chk("t1_dout", 32'(bus.dataout), 32'h50BC);
      chk("t1_kchar", 32'(bus.kchar), 32'h1);
      chk("t1_blk_cnt", 32'(blk_cnt), 32'h0);

      // Single L=3 block on channel 3
      stream.delete();
      fifo[3].push_back(16'h8603);
      fifo[3].push_back(16'h1111);
      fifo[3].push_back(16'h2222);
      fifo[3].push_back(16'h3333);
      repeat (12) cycle();
      chk("t2_rd3_cnt", 32'(rd_cnt[3]), 32'd4);
      chk("t2_nwords", 32'(data_words()), 32'd4);
      chk("t2_hdr_pos", 32'(find_word(16'h8603) >= 0), 32'd1);
      chk("t2_w3_after_w1", 32'(find_word(16'h3333) - find_word(16'h1111)), 32'd2);
      chk("t2_blk_cnt", 32'(blk_cnt), 32'd1);

      // en low: no grant until enabled
      en_s = 1'b0;
      fifo[4].push_back(hdr(4, 1));
      fifo[4].push_back(16'h4444);
      repeat (8) cycle();
      chk("t2_en_off_rd", 32'(rd_cnt[4]), 32'd0);
      en_s = 1'b1;
      repeat (8) cycle();
      chk("t2_en_on_rd", 32'(rd_cnt[4]), 32'd2);
      chk("t2_en_blk_cnt", 32'(blk_cnt), 32'd2);

      // Round robin across channels 0, 5, 16 with wrap
      do_reset();
      grants.delete();
      for (int b = 0; b < 2; b++) begin
         foreach (fifo[c]) begin
            if (c == 0 || c == 5 || c == 16) begin
               fifo[c].push_back(hdr(c, 2));
               fifo[c].push_back(16'(c * 16 + b * 2 + 1));
               fifo[c].push_back(16'(c * 16 + b * 2 + 2));
            end
         end
      end
      repeat (50) cycle();
      chk("t3_ngrants", 32'(grants.size() >= 4), 32'd1);
      if (grants.size() >= 4) begin
         chk("t3_g0", 32'(grants[0]), 32'd0);
         chk("t3_g1", 32'(grants[1]), 32'd5);
         chk("t3_g2", 32'(grants[2]), 32'd16);
         chk("t3_g3", 32'(grants[3]), 32'd0);
      end
      chk("t3_blk_cnt", 32'(blk_cnt), 32'd6);

      // Channel 7 stalls 10 cycles after word 2
      pre = int'(blk_cnt);
      stream.delete(); et_cnt = 0; rd_cnt[7] = 0;
      fifo[7].push_back(hdr(7, 5));
      for (int w = 1; w <= 5; w++) fifo[7].push_back(16'(16'h7000 + w));
      n = 0;
      while (rd_cnt[7] < 3 && n < 40) begin cycle(); n++; end
      chk("t4_reach_w2", 32'(rd_cnt[7] >= 3), 32'd1);
      hold[7] = 1'b1;
      repeat (10) cycle();
      hold[7] = 1'b0;
      repeat (10) cycle();
      i2 = find_word(16'h7002);
      i3 = find_word(16'h7003);
      chk("t4_gap", 32'(i3 - i2 - 1), 32'd10);
      chk("t4_w5_seen", 32'(find_word(16'h7005) > i3), 32'd1);
      chk("t4_no_tmo", 32'(et_cnt), 32'd0);
      chk("t4_blk_cnt", 32'(blk_cnt), 32'(pre + 1));

      // Channel 2 abandoned on timeout, pointer lands on 3
      pre = int'(blk_cnt);
      et_cnt = 0; rd_cnt[2] = 0;
      fifo[2].push_back(hdr(2, 4));
      for (int w = 1; w <= 4; w++) fifo[2].push_back(16'(16'h2000 + w));
      n = 0;
      while (rd_cnt[2] < 2 && n < 40) begin cycle(); n++; end
      chk("t5_reach_w1", 32'(rd_cnt[2] >= 2), 32'd1);
      hold[2] = 1'b1;
      repeat (TMO + 5) cycle();
      chk("t5_tmo_pulses", 32'(et_cnt), 32'd1);
      chk("t5_idle", 32'(busy), 32'd0);
      chk("t5_blk_cnt", 32'(blk_cnt), 32'(pre));
      fifo[2].delete();
      hold[2] = 1'b0;
      grants.delete();
      fifo[1].push_back(hdr(1, 0));
      fifo[3].push_back(hdr(3, 0));
      repeat (10) cycle();
      chk("t5_ngrants", 32'(grants.size()), 32'd2);
      if (grants.size() >= 2) begin
         chk("t5_first_p3", 32'(grants[0]), 32'd3);
         chk("t5_then_1", 32'(grants[1]), 32'd1);
      end

      // Format error, then an L=0 block
      pre = int'(blk_cnt);
      ef_cnt = 0; rd_cnt[1] = 0;
      fifo[1].push_back(16'h0203);
      repeat (6) cycle();
      chk("t6_rd1", 32'(rd_cnt[1]), 32'd1);
      chk("t6_fmt_pulses", 32'(ef_cnt), 32'd1);
      chk("t6_blk_cnt", 32'(blk_cnt), 32'(pre));
      chk("t6_fifo_empty", 32'(fifo[1].size()), 32'd0);
      stream.delete();
      fifo[1].push_back(16'h8200);
      repeat (6) cycle();
      chk("t6_l0_words", 32'(data_words()), 32'd1);
      chk("t6_l0_hdr", 32'(find_word(16'h8200) >= 0), 32'd1);
      chk("t6_l0_blk_cnt", 32'(blk_cnt), 32'(pre + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
